cpu_run_monitor: RTL and testbench
==================================

// Module: cpu_run_monitor
// PURPOSE
//  Synthesizable run controller/monitor wrapped around the cpu core. Sequences the core's
//  reset, counts run cycles, detects program end (PC self-loop held HALT_CYCLES cycles),
//  enforces a cycle timeout and latches pass/fail against an expected result. It replaces
//  fixed-delay reset/finish sequencing so sims and FPGA builds stop on completion.
// PARAMETERS
//  ADDRESS_WIDTH   32    width of pcw
//  DATA_WIDTH      32    width of result / expected
//  CNT_WIDTH       32    width of cycle counter
//  RESET_CYCLES    4     cycles cpu_rst is held high after start (>=1)
//  HALT_CYCLES     4     consecutive repeated-PC samples that mean halt (>=1)
//  TIMEOUT_CYCLES  1000  max RUN cycles before timeout (>=1, < 2^CNT_WIDTH)
// PORTS
//  clk           in   1              system clock, rising edge
//  rst           in   1              synchronous, active-low reset
//  start         in   1              launch a run (honoured in IDLE and DONE only)
//  pcw           in   ADDRESS_WIDTH  core PC
//  result        in   DATA_WIDTH     core result bus
//  expected      in   DATA_WIDTH     golden result, sampled at halt
//  cpu_rst       out  1              active-high reset to core
//  running       out  1              high in RUN
//  done          out  1              high in DONE
//  pass          out  1              done by halt AND result==expected
//  timeout       out  1              done by timeout
//  cycle_count   out  CNT_WIDTH      RUN cycles elapsed; frozen in DONE
//  final_result  out  DATA_WIDTH     result captured at halt/timeout edge
// BEHAVIOUR
//  - All outputs registered. rst==0 at an edge: state IDLE, cpu_rst=1, running=done=pass=
//    timeout=0, cycle_count=0, final_result=0, internal prev_pc=0, rep_cnt=0, rst_cnt=0.
//    Reset mid-run aborts immediately; no flags preserved.
//  - FSM IDLE -> RESET -> RUN -> DONE -> (start) RESET.
//  - IDLE: cpu_rst=1. start=1 -> RESET, rst_cnt=0.
//  - RESET: cpu_rst=1 for exactly RESET_CYCLES cycles (rst_cnt 0..RESET_CYCLES-1), then RUN.
//    On entry clears done/pass/timeout/cycle_count/rep_cnt. start ignored.
//  - RUN: cpu_rst=0, running=1. Each cycle: cycle_count+=1; prev_pc<=pcw;
//    rep_cnt <= (pcw==prev_pc && not first RUN cycle) ? rep_cnt+1 : 0. start ignored.
//  - Halt: at the edge where the new rep_cnt value equals HALT_CYCLES -> DONE, done=1,
//    pass=(result==expected), final_result=result. Visible the cycle after that edge.
//  - Timeout: at the edge where the new cycle_count equals TIMEOUT_CYCLES and no halt ->
//    DONE, done=1, timeout=1, pass=0, final_result=result.
//  - Halt and timeout on the same edge: halt wins, timeout=0, pass per compare.
//  - DONE: cpu_rst=1 (core frozen), running=0, flags/count/final_result held. start -> RESET.
//  - done, pass, timeout mutually consistent: pass or timeout implies done; never both.
//  - cycle_count never wraps (bounded by TIMEOUT_CYCLES). Compare is full-width equality.
// TESTING (RESET_CYCLES=2, HALT_CYCLES=4, TIMEOUT_CYCLES=100)
//  1 rst=0 two cycles, release, no start -> cpu_rst=1, all flags 0, cycle_count=0 indefinitely.
//  2 start 1 cycle -> cpu_rst high exactly 2 cycles, then running=1, cycle_count 1,2,3...
//  3 pcw 0,4,8,C,C,C,C,C, result=0x2A, expected=0x2A -> done=1 pass=1 one cycle after 4th
//    repeat, final_result=0x2A, cycle_count=8, cpu_rst=1.
//  4 same PC trace, expected=0x2B -> done=1 pass=0 timeout=0.
//  5 pcw increments every cycle -> timeout=1 done=1 pass=0 cycle_count=100 exactly.
//  6 PC loop aligned so 4th repeat lands on RUN cycle 100 -> pass/halt wins, timeout=0;
//    then rst=0 mid-next-run clears all outputs; start from DONE re-runs with flags cleared.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// Purpose : run controller/monitor around the cpu core: sequences core reset, counts run
//           cycles, detects halt (PC self-loop), enforces a timeout, latches pass/fail.
// Latency : all outputs registered; halt/timeout flags visible the cycle after the deciding edge.
// Backpr. : none; start is a level sampled only in IDLE and DONE, ignored elsewhere.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   start        launch a run (IDLE or DONE only)
//   pcw          core program counter
//   result       core result bus
//   expected     golden result, compared at halt
//   cpu_rst      active-high reset to the core (high outside RUN)
//   running      high while the core is running
//   done         run finished (halt or timeout)
//   pass         finished by halt with result == expected
//   timeout      finished by cycle budget exhaustion
//   cycle_count  RUN cycles elapsed, frozen once done
//   final_result result captured on the finishing edge
module cpu_run_monitor #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 32,
    parameter int RESET_CYCLES   = 4,
    parameter int HALT_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] pcw,
    input  logic [DATA_WIDTH-1:0]    result,
    input  logic [DATA_WIDTH-1:0]    expected,
    output logic                     cpu_rst,
    output logic                     running,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [CNT_WIDTH-1:0]     cycle_count,
    output logic [DATA_WIDTH-1:0]    final_result
);

    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam int REP_W = $clog2(HALT_CYCLES + 1);

    localparam logic [RST_W-1:0]     RST_LAST    = RST_W'(RESET_CYCLES - 1);
    localparam logic [REP_W-1:0]     REP_HALT    = REP_W'(HALT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                   state_q,        state_d;
    logic [RST_W-1:0]         rst_cnt_q,      rst_cnt_d;
    logic [REP_W-1:0]         rep_cnt_q,      rep_cnt_d;
    logic [ADDRESS_WIDTH-1:0] prev_pc_q,      prev_pc_d;
    logic [CNT_WIDTH-1:0]     cycle_count_q,  cycle_count_d;
    logic [DATA_WIDTH-1:0]    final_result_q, final_result_d;
    logic                     cpu_rst_q,      cpu_rst_d;
    logic                     running_q,      running_d;
    logic                     done_q,         done_d;
    logic                     pass_q,         pass_d;
    logic                     timeout_q,      timeout_d;

    // Next values of the run counters, used by the halt/timeout decision this cycle.
    logic [CNT_WIDTH-1:0]     cnt_next;
    logic [REP_W-1:0]         rep_next;
    logic                     halt_hit;
    logic                     timeout_hit;

    always_comb begin
        // cycle_count is cleared on entry to RESET, so zero here marks the first RUN
        // cycle, where prev_pc still holds a stale value and must not count as a repeat.
        cnt_next    = cycle_count_q + CNT_WIDTH'(1);
        rep_next    = ((pcw == prev_pc_q) && (cycle_count_q != '0)) ?
                      rep_cnt_q + REP_W'(1) : '0;
        halt_hit    = (rep_next == REP_HALT);
        timeout_hit = (cnt_next == CNT_TIMEOUT);
    end

    always_comb begin
        state_d        = state_q;
        rst_cnt_d      = rst_cnt_q;
        rep_cnt_d      = rep_cnt_q;
        prev_pc_d      = prev_pc_q;
        cycle_count_d  = cycle_count_q;
        final_result_d = final_result_q;
        cpu_rst_d      = cpu_rst_q;
        running_d      = running_q;
        done_d         = done_q;
        pass_d         = pass_q;
        timeout_d      = timeout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Core stays frozen; a finished run's flags hold until the next start.
                cpu_rst_d = 1'b1;
                running_d = 1'b0;
                if (start) begin
                    state_d       = ST_RESET;
                    rst_cnt_d     = '0;
                    rep_cnt_d     = '0;
                    cycle_count_d = '0;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    timeout_d     = 1'b0;
                end
            end

            ST_RESET: begin
                cpu_rst_d = 1'b1;
                running_d = 1'b0;
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_RUN;
                    cpu_rst_d = 1'b0;
                    running_d = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end

            ST_RUN: begin
                cycle_count_d = cnt_next;
                prev_pc_d     = pcw;
                rep_cnt_d     = rep_next;
                // Halt takes priority over a timeout landing on the same edge.
                if (halt_hit || timeout_hit) begin
                    state_d        = ST_DONE;
                    cpu_rst_d      = 1'b1;
                    running_d      = 1'b0;
                    done_d         = 1'b1;
                    final_result_d = result;
                    pass_d         = halt_hit && (result == expected);
                    timeout_d      = !halt_hit;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cpu_rst_d = 1'b1;
                running_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            rst_cnt_q      <= '0;
            rep_cnt_q      <= '0;
            prev_pc_q      <= '0;
            cycle_count_q  <= '0;
            final_result_q <= '0;
            cpu_rst_q      <= 1'b1;
            running_q      <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            rep_cnt_q      <= rep_cnt_d;
            prev_pc_q      <= prev_pc_d;
            cycle_count_q  <= cycle_count_d;
            final_result_q <= final_result_d;
            cpu_rst_q      <= cpu_rst_d;
            running_q      <= running_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            timeout_q      <= timeout_d;
        end
    end

    assign cpu_rst      = cpu_rst_q;
    assign running      = running_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign cycle_count  = cycle_count_q;
    assign final_result = final_result_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Purpose : directed self-checking bench for cpu_run_monitor (short reset/halt/timeout params).
// Latency : inputs driven and outputs sampled on the falling edge, half a cycle from the flops.
// Backpr. : none; every phase runs a fixed number of cycles.
module tb_cpu_run_monitor;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] pcw;
    logic [DW-1:0] result;
    logic [DW-1:0] expected;
    logic          cpu_rst;
    logic          running;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [CW-1:0] cycle_count;
    logic [DW-1:0] final_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_run_monitor #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .CNT_WIDTH     (CW),
        .RESET_CYCLES  (2),
        .HALT_CYCLES   (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pcw          (pcw),
        .result       (result),
        .expected     (expected),
        .cpu_rst      (cpu_rst),
        .running      (running),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .cycle_count  (cycle_count),
        .final_result (final_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs after a reset or between runs with nothing latched.
    task automatic check_idle(input string tag);
        check({tag, ".cpu_rst"}, 64'(cpu_rst), 64'd1);
        check({tag, ".running"}, 64'(running), 64'd0);
        check({tag, ".done"},    64'(done),    64'd0);
        check({tag, ".pass"},    64'(pass),    64'd0);
        check({tag, ".timeout"}, 64'(timeout), 64'd0);
        check({tag, ".count"},   64'(cycle_count),  64'd0);
        check({tag, ".final"},   64'(final_result), 64'd0);
    endtask

    // Pulse start, check the two RESET cycles, return on the falling edge of RUN cycle 1.
    task automatic launch(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".rst1.cpu_rst"}, 64'(cpu_rst), 64'd1);
        check({tag, ".rst1.running"}, 64'(running), 64'd0);
        check({tag, ".rst1.done"},    64'(done),    64'd0);
        check({tag, ".rst1.pass"},    64'(pass),    64'd0);
        check({tag, ".rst1.timeout"}, 64'(timeout), 64'd0);
        check({tag, ".rst1.count"},   64'(cycle_count), 64'd0);
        @(negedge clk);
        check({tag, ".rst2.cpu_rst"}, 64'(cpu_rst), 64'd1);
        check({tag, ".rst2.running"}, 64'(running), 64'd0);
        @(negedge clk);
        check({tag, ".run0.cpu_rst"}, 64'(cpu_rst), 64'd0);
        check({tag, ".run0.running"}, 64'(running), 64'd1);
        check({tag, ".run0.count"},   64'(cycle_count), 64'd0);
    endtask

    // Halt trace: 0,4,8,C then C repeated four times -> halt on RUN edge 8.
    task automatic halt_run(input string tag, input logic [DW-1:0] exp_val, input logic exp_pass);
        logic [AW-1:0] trace [8];
        trace = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC};
        result   = 32'h2A;
        expected = exp_val;
        launch(tag);
        for (int k = 0; k < 8; k++) begin
            pcw = trace[k];
            @(negedge clk);
            if (k == 6) begin
                check({tag, ".pre.done"},  64'(done), 64'd0);
                check({tag, ".pre.count"}, 64'(cycle_count), 64'd7);
            end
        end
        check({tag, ".done"},    64'(done),    64'd1);
        check({tag, ".pass"},    64'(pass),    64'(exp_pass));
        check({tag, ".timeout"}, 64'(timeout), 64'd0);
        check({tag, ".count"},   64'(cycle_count),  64'd8);
        check({tag, ".final"},   64'(final_result), 64'h2A);
        check({tag, ".cpu_rst"}, 64'(cpu_rst), 64'd1);
        check({tag, ".running"}, 64'(running), 64'd0);
        // DONE holds everything while the PC keeps moving.
        for (int k = 0; k < 3; k++) begin
            pcw = 32'h100 + 32'(k);
            @(negedge clk);
        end
        check({tag, ".hold.done"},  64'(done), 64'd1);
        check({tag, ".hold.pass"},  64'(pass), 64'(exp_pass));
        check({tag, ".hold.count"}, 64'(cycle_count), 64'd8);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        pcw      = '0;
        result   = '0;
        expected = '0;

        // 1: reset then idle with no start.
        @(negedge clk);
        @(negedge clk);
        check_idle("rst");
        rst = 1'b1;
        for (int k = 0; k < 6; k++) @(negedge clk);
        check_idle("idle");

        // 2 + 3: launch, count, halt with matching result.
        halt_run("halt_pass", 32'h2A, 1'b1);

        // 4: restart from DONE, mismatching expected value.
        halt_run("halt_fail", 32'h2B, 1'b0);

        // 5: free-running PC -> timeout at exactly 100 cycles.
        result   = 32'h77;
        expected = 32'h77;
        launch("tmo");
        for (int k = 1; k <= 100; k++) begin
            pcw = 32'(4 * k);
            @(negedge clk);
            if (k == 1)  check("tmo.count1", 64'(cycle_count), 64'd1);
            if (k == 2)  check("tmo.count2", 64'(cycle_count), 64'd2);
            if (k == 99) check("tmo.pre.done", 64'(done), 64'd0);
        end
        check("tmo.done",    64'(done),    64'd1);
        check("tmo.timeout", 64'(timeout), 64'd1);
        check("tmo.pass",    64'(pass),    64'd0);
        check("tmo.count",   64'(cycle_count),  64'd100);
        check("tmo.final",   64'(final_result), 64'h77);
        check("tmo.cpu_rst", 64'(cpu_rst), 64'd1);

        // 6: 4th repeat lands on RUN cycle 100 -> halt wins over timeout.
        result   = 32'h55;
        expected = 32'h55;
        launch("tie");
        for (int k = 1; k <= 100; k++) begin
            pcw = (k <= 96) ? 32'(4 * k) : 32'(4 * 96);
            @(negedge clk);
            if (k == 99) check("tie.pre.done", 64'(done), 64'd0);
        end
        check("tie.done",    64'(done),    64'd1);
        check("tie.pass",    64'(pass),    64'd1);
        check("tie.timeout", 64'(timeout), 64'd0);
        check("tie.count",   64'(cycle_count),  64'd100);
        check("tie.final",   64'(final_result), 64'h55);

        // Reset in the middle of the next run clears everything.
        launch("abort");
        for (int k = 1; k <= 10; k++) begin
            pcw = 32'(8 * k);
            @(negedge clk);
        end
        check("abort.count", 64'(cycle_count), 64'd10);
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort");
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort.rel");

        // A fresh run after the abort halts normally.
        halt_run("rerun", 32'h2A, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
